// File: rtl/t_comp.sv
// t_comp: bit-serial two's-complement negator (LSB first, one registered cycle of latency).
// Define TCOMP_WORD_RESTART_EN to restart automatically every WORD_LEN bits instead of needing a reset.
module t_comp #(
    parameter int WORD_LEN = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic b
);
    typedef enum logic {S_COPY, S_INV} state_t;
    state_t r_state, w_next;
    logic   w_b;
    if (WORD_LEN < 1) begin : g_chk
        $error("WORD_LEN must be at least 1");
    end
`ifdef TCOMP_WORD_RESTART_EN
    localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    logic [CW-1:0] r_cnt;
    logic          w_last;
    assign w_last = (r_cnt == CW'(WORD_LEN - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
`endif
    always_comb begin
        w_b    = (r_state == S_COPY) ? a : ~a;
        w_next = (r_state == S_COPY && !a) ? S_COPY : S_INV;
`ifdef TCOMP_WORD_RESTART_EN
        if (w_last) w_next = S_COPY;
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_COPY;
            b       <= 1'b0;
        end else begin
            r_state <= w_next;
            b       <= w_b;
        end
    end
endmodule

// File: tb/tb_t_comp.sv
// tb_t_comp: directed-vector bench for the serial negator; b is sampled 1 ns after each rising edge.
module tb_t_comp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic b;
    int   errors = 0;
    int   checks = 0;

    t_comp #(.WORD_LEN(32)) dut (.clk(clk), .rst(rst), .a(a), .b(b));

    always #5 clk = ~clk;

    task automatic stream(input logic [31:0] w, output logic [31:0] r);
        for (int i = 0; i < 32; i++) begin
            a = w[i];
            @(posedge clk);
            #1;
            r[i] = b;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        a   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a   = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: b=%b expected 0", i, b);
            end
        end
        rst = 1'b1;
        a   = 1'b0;
        #1;
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: b=%b expected 0", b);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vin [5];
        logic [31:0] vexp[5];
        logic [31:0] r;
        vin[0] = 32'h0000_2C44; vexp[0] = 32'hFFFF_D3BC;
        vin[1] = 32'h0000_0000; vexp[1] = 32'h0000_0000;
        vin[2] = 32'h0000_0001; vexp[2] = 32'hFFFF_FFFF;
        vin[3] = 32'h8000_0000; vexp[3] = 32'h8000_0000;
        vin[4] = 32'hFFFF_FFFF; vexp[4] = 32'h0000_0001;
        for (int k = 0; k < 5; k++) begin
            do_reset();
            stream(vin[k], r);
            checks++;
            if (r !== vexp[k]) begin
                errors++;
                $display("FAIL negate(%h): got %h expected %h", vin[k], r, vexp[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0]  p;
        logic [31:0] r;
        p = 8'h10;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a = p[i];
            @(posedge clk);
            #1;
        end
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: b=%b expected 1", b);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: b=%b expected 0", b);
        end
        @(negedge clk);
        rst = 1'b1;
        stream(32'h0000_0002, r);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL after_mid_reset: got %h expected fffffffe", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2, e2;
`ifdef TCOMP_WORD_RESTART_EN
        e2 = 32'hFFFF_FFFC;
`else
        e2 = 32'hFFFF_FFFB;
`endif
        do_reset();
        stream(32'h0000_0001, r1);
        stream(32'h0000_0004, r2);
        checks++;
        if (r1 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_word0: got %h expected ffffffff", r1);
        end
        checks++;
        if (r2 !== e2) begin
            errors++;
            $display("FAIL b2b_word1: got %h expected %h", r2, e2);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
